// File: rtl/wb_regfile_pkg.sv
// wb_regfile_pkg: shared constants for the writeback register file.
//   - RV32I major opcodes (7-bit) seen on the writeback and issue paths
//   - ZeroWord: canonical zero data word
//   - writes_rd(): true when an opcode commits a value to rd
package wb_regfile_pkg;

  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] ALOPI     = 7'b0010011;
  localparam logic [6:0] ALOP      = 7'b0110011;

  localparam logic [31:0] ZeroWord = 32'h0000_0000;

  // STORE, BRANCH and anything unrecognised leave rd untouched.
  function automatic logic writes_rd(input logic [6:0] op);
    case (op)
      OP_LUI, OP_AUIPC, OP_JAL, OP_JALR,
      OP_LOAD, ALOPI, ALOP: writes_rd = 1'b1;
      default:              writes_rd = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/wb_regfile_scoreboard.sv
// Pending-write scoreboard.
//   wb_sb_cell    : one saturating up/down counter per architectural register.
//   wb_scoreboard : NREG cells plus the sticky overflow flag.
// Ports (wb_scoreboard):
//   clk_in, rst_n_in   clock, async active-low reset
//   rdy_in             global enable, all state holds when low
//   flush              clears every counter, drops the issue of that cycle
//   inc_vec / dec_vec  one-hot issue / writeback strobes per register
//   cnt                packed counter values, cnt[r] for register r
//   sb_overflow        sticky, set when a saturated counter is incremented
module wb_sb_cell #(
  parameter int CNT_W = 2
) (
  input  logic             clk_in,
  input  logic             rst_n_in,
  input  logic             rdy_in,
  input  logic             flush,
  input  logic             inc,
  input  logic             dec,
  output logic [CNT_W-1:0] cnt,
  output logic             ovf_evt
);
  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Overflow is only meaningful for an issue that is actually taken.
  assign ovf_evt = rdy_in && !flush && inc && !dec && (cnt == CNT_MAX);

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cnt <= '0;
    end else if (rdy_in) begin
      if (flush) begin
        cnt <= '0;
      end else if (inc && !dec) begin
        if (cnt != CNT_MAX) cnt <= cnt + 1'b1;
      end else if (dec && !inc) begin
        // Writebacks of squashed instructions land here with cnt==0.
        if (cnt != '0) cnt <= cnt - 1'b1;
      end
    end
  end
endmodule

module wb_scoreboard
  import wb_regfile_pkg::*;
#(
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic                       clk_in,
  input  logic                       rst_n_in,
  input  logic                       rdy_in,
  input  logic                       flush,
  input  logic [NREG-1:0]            inc_vec,
  input  logic [NREG-1:0]            dec_vec,
  output logic [NREG-1:0][CNT_W-1:0] cnt,
  output logic                       sb_overflow
);
  logic [NREG-1:0] ovf_evt;

  genvar r;
  generate
    for (r = 0; r < NREG; r++) begin : g_cell
      wb_sb_cell #(.CNT_W(CNT_W)) u_cell (
        .clk_in   (clk_in),
        .rst_n_in (rst_n_in),
        .rdy_in   (rdy_in),
        .flush    (flush),
        .inc      (inc_vec[r]),
        .dec      (dec_vec[r]),
        .cnt      (cnt[r]),
        .ovf_evt  (ovf_evt[r])
      );
    end
  endgenerate

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in)     sb_overflow <= 1'b0;
    else if (|ovf_evt) sb_overflow <= 1'b1;
  end
endmodule

// File: rtl/wb_regfile.sv
// wb_regfile: architectural integer register file, MEM/WB consumer end.
//   Commits {wb_rd_addr, wb_rd_val, wb_ins_type} to x1..x31, serves two
//   combinational read ports, and keeps a pending-write scoreboard for
//   RAW hazard detection in decode.
// Ports:
//   clk_in, rst_n_in                   clock, async active-low reset
//   rdy_in                             global enable
//   flush                              clears the scoreboard
//   wb_rd_addr/wb_rd_val/wb_ins_type   writeback triple
//   issue_en/issue_rd_addr/issue_ins_type  decode issue
//   rs1_addr/rs2_addr -> rs1_val/rs2_val, rs1_busy/rs2_busy
//   sb_overflow                        sticky scoreboard overflow
// Option: define WB_REGFILE_FORWARD_EN for same-cycle writeback bypass on
//   the read data and busy outputs.
module wb_regfile
  import wb_regfile_pkg::*;
#(
  parameter int XLEN  = 32,
  parameter int NREG  = 32,
  parameter int CNT_W = 2
) (
  input  logic            clk_in,
  input  logic            rst_n_in,
  input  logic            rdy_in,
  input  logic            flush,
  input  logic [4:0]      wb_rd_addr,
  input  logic [XLEN-1:0] wb_rd_val,
  input  logic [6:0]      wb_ins_type,
  input  logic            issue_en,
  input  logic [4:0]      issue_rd_addr,
  input  logic [6:0]      issue_ins_type,
  input  logic [4:0]      rs1_addr,
  input  logic [4:0]      rs2_addr,
  output logic [XLEN-1:0] rs1_val,
  output logic [XLEN-1:0] rs2_val,
  output logic            rs1_busy,
  output logic            rs2_busy,
  output logic            sb_overflow
);
  logic [XLEN-1:0]            rf [NREG];
  logic [NREG-1:0][CNT_W-1:0] cnt;
  logic [NREG-1:0]            inc_vec, dec_vec;
  logic                       wb_we, iss_we;

  assign wb_we  = writes_rd(wb_ins_type) && (wb_rd_addr != 5'd0);
  assign iss_we = issue_en && writes_rd(issue_ins_type) && (issue_rd_addr != 5'd0);

  // x0 never gets a strobe since both qualifiers exclude address 0.
  always_comb begin
    inc_vec = '0;
    dec_vec = '0;
    for (int r = 0; r < NREG; r++) begin
      inc_vec[r] = iss_we && (issue_rd_addr == 5'(r));
      dec_vec[r] = wb_we  && (wb_rd_addr    == 5'(r));
    end
  end

  // Register array; rf[0] resets to zero and is never written.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      for (int r = 0; r < NREG; r++) rf[r] <= XLEN'(ZeroWord);
    end else if (rdy_in) begin
      for (int r = 0; r < NREG; r++)
        if (dec_vec[r]) rf[r] <= wb_rd_val;
    end
  end

  wb_scoreboard #(.NREG(NREG), .CNT_W(CNT_W)) u_sb (
    .clk_in      (clk_in),
    .rst_n_in    (rst_n_in),
    .rdy_in      (rdy_in),
    .flush       (flush),
    .inc_vec     (inc_vec),
    .dec_vec     (dec_vec),
    .cnt         (cnt),
    .sb_overflow (sb_overflow)
  );

  logic rs1_cnt_nz, rs2_cnt_nz;
  assign rs1_cnt_nz = (cnt[rs1_addr] != '0);
  assign rs2_cnt_nz = (cnt[rs2_addr] != '0);

`ifdef WB_REGFILE_FORWARD_EN
  // Bypass ignores rdy_in: a stalled writeback still presents its data.
  logic rs1_hit, rs2_hit, rs1_last, rs2_last;
  assign rs1_hit  = wb_we && (wb_rd_addr == rs1_addr);
  assign rs2_hit  = wb_we && (wb_rd_addr == rs2_addr);
  // The writeback in flight retires the only outstanding write.
  assign rs1_last = rs1_hit && (cnt[rs1_addr] == CNT_W'(1));
  assign rs2_last = rs2_hit && (cnt[rs2_addr] == CNT_W'(1));

  always_comb begin
    rs1_val  = XLEN'(ZeroWord);
    rs2_val  = XLEN'(ZeroWord);
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rs1_addr != 5'd0) begin
      rs1_val  = rs1_hit ? wb_rd_val : rf[rs1_addr];
      rs1_busy = rs1_cnt_nz && !rs1_last;
    end
    if (rs2_addr != 5'd0) begin
      rs2_val  = rs2_hit ? wb_rd_val : rf[rs2_addr];
      rs2_busy = rs2_cnt_nz && !rs2_last;
    end
  end
`else
  always_comb begin
    rs1_val  = XLEN'(ZeroWord);
    rs2_val  = XLEN'(ZeroWord);
    rs1_busy = 1'b0;
    rs2_busy = 1'b0;
    if (rs1_addr != 5'd0) begin
      rs1_val  = rf[rs1_addr];
      rs1_busy = rs1_cnt_nz;
    end
    if (rs2_addr != 5'd0) begin
      rs2_val  = rf[rs2_addr];
      rs2_busy = rs2_cnt_nz;
    end
  end
`endif

endmodule

// File: tb/tb_wb_regfile.sv
// Directed bench for wb_regfile: reset, writeback qualification, scoreboard
// counting/saturation/underflow, flush, rdy_in stall and same-cycle reads.
module tb_wb_regfile;
  import wb_regfile_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        rdy_in, flush, issue_en;
  logic [4:0]  wb_rd_addr, issue_rd_addr, rs1_addr, rs2_addr;
  logic [31:0] wb_rd_val, rs1_val, rs2_val;
  logic [6:0]  wb_ins_type, issue_ins_type;
  logic        rs1_busy, rs2_busy, sb_overflow;

  int checks = 0;
  int failures = 0;

  always #5 clk_in = ~clk_in;

  wb_regfile dut (
    .clk_in(clk_in), .rst_n_in(rst_n_in), .rdy_in(rdy_in), .flush(flush),
    .wb_rd_addr(wb_rd_addr), .wb_rd_val(wb_rd_val), .wb_ins_type(wb_ins_type),
    .issue_en(issue_en), .issue_rd_addr(issue_rd_addr),
    .issue_ins_type(issue_ins_type), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rs1_val(rs1_val), .rs2_val(rs2_val), .rs1_busy(rs1_busy),
    .rs2_busy(rs2_busy), .sb_overflow(sb_overflow)
  );

  typedef struct {
    logic        iss_en;
    logic [4:0]  iss_rd;
    logic [6:0]  iss_t;
    logic [4:0]  wb_rd;
    logic [31:0] wb_val;
    logic [6:0]  wb_t;
    logic        fl;
    logic        rdy;
    logic [4:0]  rs1, rs2;
    logic [31:0] e1, e2;
    logic        eb1, eb2, eovf;
  } vec_t;

  localparam int NV = 25;
  vec_t tbl [NV];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Non-writing writeback, no issue, enabled; read addresses untouched.
  task automatic idle();
    issue_en = 1'b0; issue_rd_addr = 5'd0; issue_ins_type = OP_STORE;
    wb_rd_addr = 5'd0; wb_rd_val = 32'h0; wb_ins_type = OP_STORE;
    flush = 1'b0; rdy_in = 1'b1;
  endtask

  task automatic step();
    @(posedge clk_in);
    #1;
  endtask

  initial begin
    //            iss rd  type      wb  val            type       fl rdy rs1 rs2  e1             e2             b1 b2 ovf
    tbl[0]  = '{1'b0, 0, OP_STORE,  5, 32'hDEADBEEF, ALOP,      0, 1,  5,  0, 32'hDEADBEEF, 32'h0,        0, 0, 0};
    tbl[1]  = '{1'b0, 0, OP_STORE,  0, 32'hFFFFFFFF, ALOP,      0, 1,  0,  5, 32'h0,        32'hDEADBEEF, 0, 0, 0};
    tbl[2]  = '{1'b0, 0, OP_STORE,  7, 32'h1,        OP_STORE,  0, 1,  7,  5, 32'h0,        32'hDEADBEEF, 0, 0, 0};
    tbl[3]  = '{1'b0, 0, OP_STORE,  7, 32'h77,       ALOP,      0, 1,  7,  5, 32'h77,       32'hDEADBEEF, 0, 0, 0};
    tbl[4]  = '{1'b0, 0, OP_STORE,  7, 32'h1,        OP_STORE,  0, 1,  7,  0, 32'h77,       32'h0,        0, 0, 0};
    tbl[5]  = '{1'b0, 0, OP_STORE,  7, 32'h2,        OP_BRANCH, 0, 1,  7,  0, 32'h77,       32'h0,        0, 0, 0};
    tbl[6]  = '{1'b1, 3, OP_LOAD,   0, 32'h0,        OP_STORE,  0, 1,  3,  7, 32'h0,        32'h77,       1, 0, 0};
    tbl[7]  = '{1'b1, 3, OP_LOAD,   0, 32'h0,        OP_STORE,  0, 1,  3,  7, 32'h0,        32'h77,       1, 0, 0};
    tbl[8]  = '{1'b0, 0, OP_STORE,  3, 32'h33,       OP_LOAD,   0, 1,  3,  7, 32'h33,       32'h77,       1, 0, 0};
    tbl[9]  = '{1'b1, 3, OP_LOAD,   3, 32'h34,       ALOP,      0, 1,  3,  7, 32'h34,       32'h77,       1, 0, 0};
    tbl[10] = '{1'b0, 0, OP_STORE,  3, 32'h35,       ALOP,      0, 1,  3,  7, 32'h35,       32'h77,       0, 0, 0};
    tbl[11] = '{1'b0, 0, OP_STORE,  3, 32'h36,       ALOP,      0, 1,  3,  7, 32'h36,       32'h77,       0, 0, 0};
    tbl[12] = '{1'b1, 4, ALOP,      0, 32'h0,        OP_STORE,  0, 1,  0,  4, 32'h0,        32'h0,        0, 1, 0};
    tbl[13] = '{1'b1, 4, ALOP,      0, 32'h0,        OP_STORE,  0, 1,  0,  4, 32'h0,        32'h0,        0, 1, 0};
    tbl[14] = '{1'b1, 4, ALOP,      0, 32'h0,        OP_STORE,  0, 1,  0,  4, 32'h0,        32'h0,        0, 1, 0};
    tbl[15] = '{1'b1, 4, ALOP,      0, 32'h0,        OP_STORE,  0, 1,  0,  4, 32'h0,        32'h0,        0, 1, 1};
    tbl[16] = '{1'b1, 8, OP_STORE,  0, 32'h0,        OP_STORE,  0, 1,  8,  0, 32'h0,        32'h0,        0, 0, 1};
    tbl[17] = '{1'b1, 0, ALOP,      0, 32'h0,        OP_STORE,  0, 1,  0,  4, 32'h0,        32'h0,        0, 1, 1};
    tbl[18] = '{1'b0, 0, OP_STORE,  4, 32'h44,       ALOP,      0, 1,  4,  0, 32'h44,       32'h0,        1, 0, 1};
    tbl[19] = '{1'b1, 6, OP_LOAD,   0, 32'h0,        OP_STORE,  0, 1,  6,  0, 32'h0,        32'h0,        1, 0, 1};
    tbl[20] = '{1'b1, 6, OP_LOAD,   0, 32'h0,        OP_STORE,  0, 1,  6,  0, 32'h0,        32'h0,        1, 0, 1};
    tbl[21] = '{1'b1, 6, OP_LOAD,  10, 32'hA0,       ALOP,      1, 1,  6, 10, 32'h0,        32'hA0,       0, 0, 1};
    tbl[22] = '{1'b0, 0, OP_STORE,  6, 32'h61,       OP_LOAD,   0, 1,  6,  4, 32'h61,       32'h44,       0, 0, 1};
    tbl[23] = '{1'b0, 0, OP_STORE,  6, 32'h62,       ALOP,      0, 1,  6,  4, 32'h62,       32'h44,       0, 0, 1};
    tbl[24] = '{1'b1, 11, ALOP,    11, 32'hBB,       ALOP,      0, 0, 11,  6, 32'h0,        32'h62,       0, 0, 1};

    idle();
    rs1_addr = 5'd5; rs2_addr = 5'd0;

    // Reset clears a previously written register asynchronously.
    #12 rst_n_in = 1'b1;
    @(negedge clk_in);
    wb_rd_addr = 5'd5; wb_rd_val = 32'hAA; wb_ins_type = ALOP;
    issue_en = 1'b1; issue_rd_addr = 5'd5; issue_ins_type = ALOP;
    step();
    idle();
    #1;
    chk("pre_reset_x5", rs1_val, 32'hAA);
    #2 rst_n_in = 1'b0;
    #1;
    chk("reset_x5_val", rs1_val, 32'h0);
    chk("reset_x5_busy", {31'b0, rs1_busy}, 32'h0);
    chk("reset_ovf", {31'b0, sb_overflow}, 32'h0);
    @(negedge clk_in);
    rst_n_in = 1'b1;

    for (int i = 0; i < NV; i++) begin
      issue_en = tbl[i].iss_en; issue_rd_addr = tbl[i].iss_rd; issue_ins_type = tbl[i].iss_t;
      wb_rd_addr = tbl[i].wb_rd; wb_rd_val = tbl[i].wb_val; wb_ins_type = tbl[i].wb_t;
      flush = tbl[i].fl; rdy_in = tbl[i].rdy;
      rs1_addr = tbl[i].rs1; rs2_addr = tbl[i].rs2;
      step();
      idle();
      #1;
      chk($sformatf("v%0d_rs1_val", i), rs1_val, tbl[i].e1);
      chk($sformatf("v%0d_rs2_val", i), rs2_val, tbl[i].e2);
      chk($sformatf("v%0d_rs1_busy", i), {31'b0, rs1_busy}, {31'b0, tbl[i].eb1});
      chk($sformatf("v%0d_rs2_busy", i), {31'b0, rs2_busy}, {31'b0, tbl[i].eb2});
      chk($sformatf("v%0d_ovf", i), {31'b0, sb_overflow}, {31'b0, tbl[i].eovf});
    end

    // Same-cycle writeback vs. read of x9 with one outstanding write.
    rs1_addr = 5'd0; rs2_addr = 5'd9;
    wb_rd_addr = 5'd9; wb_rd_val = 32'h5555; wb_ins_type = ALOP;
    step();
    idle();
    issue_en = 1'b1; issue_rd_addr = 5'd9; issue_ins_type = ALOP;
    step();
    idle();
    #1;
    chk("x9_setup_val", rs2_val, 32'h5555);
    chk("x9_setup_busy", {31'b0, rs2_busy}, 32'h1);

    // Stalled writeback: bypass (if built in) is visible, commit is not.
    wb_rd_addr = 5'd9; wb_rd_val = 32'h1234; wb_ins_type = ALOP; rdy_in = 1'b0;
    #1;
`ifdef WB_REGFILE_FORWARD_EN
    chk("stall_same_cycle_val", rs2_val, 32'h1234);
    chk("stall_same_cycle_busy", {31'b0, rs2_busy}, 32'h0);
`else
    chk("stall_same_cycle_val", rs2_val, 32'h5555);
    chk("stall_same_cycle_busy", {31'b0, rs2_busy}, 32'h1);
`endif
    step();
    idle();
    #1;
    chk("stall_no_commit_val", rs2_val, 32'h5555);
    chk("stall_no_commit_busy", {31'b0, rs2_busy}, 32'h1);

    wb_rd_addr = 5'd9; wb_rd_val = 32'h1234; wb_ins_type = ALOP;
    #1;
`ifdef WB_REGFILE_FORWARD_EN
    chk("fwd_same_cycle_val", rs2_val, 32'h1234);
    chk("fwd_same_cycle_busy", {31'b0, rs2_busy}, 32'h0);
`else
    chk("fwd_same_cycle_val", rs2_val, 32'h5555);
    chk("fwd_same_cycle_busy", {31'b0, rs2_busy}, 32'h1);
`endif
    step();
    idle();
    #1;
    chk("commit_x9_val", rs2_val, 32'h1234);
    chk("commit_x9_busy", {31'b0, rs2_busy}, 32'h0);
    chk("final_ovf_sticky", {31'b0, sb_overflow}, 32'h1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/wb_regfile.md
Name: wb_regfile

Overview:
- Architectural integer register file: the consumer end of the MEM/WB writeback interface.
- Accepts the rd_addr / rd_val / ins_type triple from the MEM/WB pipeline register and commits it to x1..x31.
- Serves two combinational read ports to decode.
- Keeps a per-register pending-write scoreboard that decode uses to detect RAW hazards.

Parameters:
- XLEN, 32, data width.
- NREG, 32, number of architectural registers; x0 is hardwired to zero.
- CNT_W, 2, width of each per-register pending-write counter.

Ports:
- clk_in  input  1  clock; all state updates on the rising edge.
- rst_n_in  input  1  asynchronous, active-low reset.
- rdy_in  input  1  global enable; when low, all state holds.
- flush  input  1  pipeline flush; clears the scoreboard.
- wb_rd_addr  input  5  writeback destination, from the MEM/WB register.
- wb_rd_val  input  XLEN  writeback data.
- wb_ins_type  input  7  writeback opcode.
- issue_en  input  1  decode issues an instruction this cycle.
- issue_rd_addr  input  5  destination of the issuing instruction.
- issue_ins_type  input  7  opcode of the issuing instruction.
- rs1_addr  input  5  read port 1 address.
- rs2_addr  input  5  read port 2 address.
- rs1_val  output  XLEN  read port 1 data.
- rs2_val  output  XLEN  read port 2 data.
- rs1_busy  output  1  rs1 has a pending write.
- rs2_busy  output  1  rs2 has a pending write.
- sb_overflow  output  1  sticky error: a counter was incremented while already at its maximum.

Behaviour:
- Reset (rst_n_in=0, asynchronous):
  - all registers = 0
  - all counters = 0
  - sb_overflow = 0
  - rs*_val / rs*_busy then read 0.
- Write qualifier: wb_we = writes_rd(wb_ins_type) && wb_rd_addr != 0.
  - writes_rd is true for LUI, AUIPC, JAL, JALR, LOAD, ALOPI, ALOP.
  - writes_rd is false for STORE (0100011), BRANCH (1100011) and any unknown opcode.
- Issue qualifier: iss_we = issue_en && writes_rd(issue_ins_type) && issue_rd_addr != 0.
- With rdy_in=1 on a clock edge:
  - if wb_we: reg[wb_rd_addr] <= wb_rd_val (1-cycle write latency).
  - Counter update per register r, with inc = iss_we && issue_rd_addr==r and dec = wb_we && wb_rd_addr==r:
    - inc only: cnt+1. If cnt was 2^CNT_W-1, cnt holds and sb_overflow <= 1.
    - dec only: cnt-1. At 0, cnt holds (no underflow).
    - inc and dec together: cnt unchanged.
  - flush=1: all counters <= 0 and the issue in that cycle is dropped. The register write in the same cycle still commits. Later writebacks of squashed instructions hit the underflow guard.
- rdy_in=0: registers, counters and sb_overflow hold. Reads and busy outputs stay combinational.
- Reads are combinational:
  - rsN_val = 0 when rsN_addr==0, else reg[rsN_addr].
  - rsN_busy = (cnt[rsN_addr] != 0); always 0 for x0.
- sb_overflow clears only on reset.

Optional Feature:
- Macro: WB_REGFILE_FORWARD_EN.
- Defined:
  - Same-cycle write-to-read bypass: when wb_we && wb_rd_addr==rsN_addr != 0, rsN_val = wb_rd_val.
  - When wb_we && wb_rd_addr==rsN_addr && cnt==1, rsN_busy = 0, so the consumer issues a cycle earlier.
  - Applies regardless of rdy_in.
- Undefined:
  - Reads return the pre-edge register contents.
  - Busy reflects the registered counter only.

Decomposition:
- Shared package / header holds:
  - opcode constants: OP_LUI, OP_AUIPC, OP_JAL, OP_JALR, OP_BRANCH, OP_LOAD, OP_STORE, ALOPI, ALOP
  - ZeroWord
  - the writes_rd function.
- Natural sub-module: wb_scoreboard, holding the NREG counters, inc/dec/flush logic and sb_overflow. The top module keeps the array and read muxes.

Test Plan:
- Reset with x5 written beforehand → rs1_addr=5 reads 0, rs1_busy=0, sb_overflow=0.
- wb ALOP, rd=5, val=32'hDEADBEEF, then read x5 next cycle → 32'hDEADBEEF. wb to rd=0 → x0 still reads 0.
- wb STORE, rd=7, val=1 → x7 unchanged. BRANCH, rd=7 → unchanged.
- Scoreboard:
  - issue LOAD rd=3 twice → cnt=2, busy=1.
  - one wb rd=3 → busy still 1.
  - second wb → busy 0.
  - issue and wb to rd=3 in the same cycle → cnt unchanged.
  - four issues to rd=4 with no wb → cnt=3 and sb_overflow=1, sticky.
- flush with cnt[6]=2 and a simultaneous issue rd=6 → cnt=0. Two later wb rd=6 leave cnt=0 and registers updated.
- WB_REGFILE_FORWARD_EN, wb rd=9 val=32'h1234 with rs2_addr=9 in the same cycle:
  - rs2_val=32'h1234 combinationally.
  - with cnt=1, rs2_busy=0.
  - without the macro, the old value and busy=1.
  - rdy_in=0 blocks the commit.
